// File: rtl/dtw_word_scheduler_if.sv
// Handshake and data bundle between the DTW word scheduler and its neighbours.
// Latency: none (wires only).
// Backpressure: carries char valid/ready and result valid/ready pairs.
//
// Port summary:
//   char stream : i_char_valid, o_char_ready, i_char, i_char_eow
//   dictionary  : o_dict_rd, o_dict_addr, i_dict_data (data one cycle after rd)
//   engine      : o_dtw_start, o_dtw_word, o_dtw_candidate[], i_dtw_finish, i_dtw_word
//   result      : o_result_valid, i_result_ready, o_result_word, o_result_matched,
//                 o_result_timeout, o_result_overflow
//   debug       : o_state
// master = scheduler side, slave = surrounding logic (glove, dictionary, engine, sink).
interface dtw_word_scheduler_if #(
    parameter int CAND_NUM = 20,
    parameter int CHAR_NUM = 15,
    parameter int ADDR_W   = 10
);
    localparam int W = CHAR_NUM * 8;

    logic              i_char_valid;
    logic              o_char_ready;
    logic [7:0]        i_char;
    logic              i_char_eow;

    logic              o_dict_rd;
    logic [ADDR_W-1:0] o_dict_addr;
    logic [W-1:0]      i_dict_data;

    logic              o_dtw_start;
    logic [W-1:0]      o_dtw_word;
    logic [W-1:0]      o_dtw_candidate [0:CAND_NUM-1];
    logic              i_dtw_finish;
    logic [W-1:0]      i_dtw_word;

    logic              o_result_valid;
    logic              i_result_ready;
    logic [W-1:0]      o_result_word;
    logic              o_result_matched;
    logic              o_result_timeout;
    logic              o_result_overflow;

    logic [2:0]        o_state;

    modport master (
        input  i_char_valid, i_char, i_char_eow,
        output o_char_ready,
        output o_dict_rd, o_dict_addr,
        input  i_dict_data,
        output o_dtw_start, o_dtw_word, o_dtw_candidate,
        input  i_dtw_finish, i_dtw_word,
        output o_result_valid, o_result_word, o_result_matched,
        output o_result_timeout, o_result_overflow,
        input  i_result_ready,
        output o_state
    );

    modport slave (
        output i_char_valid, i_char, i_char_eow,
        input  o_char_ready,
        input  o_dict_rd, o_dict_addr,
        output i_dict_data,
        input  o_dtw_start, o_dtw_word, o_dtw_candidate,
        output i_dtw_finish, i_dtw_word,
        input  o_result_valid, o_result_word, o_result_matched,
        input  o_result_timeout, o_result_overflow,
        output i_result_ready,
        input  o_state
    );
endinterface

// File: rtl/dtw_word_scheduler.sv
// Sequencer for the DTW engine: builds a word, fetches its dictionary group, runs the match.
// Latency: eow->start 22 cycles, finish->result 1 cycle, bypass eow->result 1 cycle.
// Backpressure: o_char_ready only in S_COLLECT; a pending result stalls the char stream.
//
// Ports:
//   i_DTW_clk   : clock, rising edge
//   i_DTW_rst_n : asynchronous reset, active HIGH despite the name (shared with the engine)
//   bus         : dtw_word_scheduler_if.master (char stream, dictionary, engine, result, debug)
module dtw_word_scheduler #(
    parameter int CAND_NUM  = 20,
    parameter int CHAR_NUM  = 15,
    parameter int ADDR_W    = 10,
    parameter int DICT_BASE = 0,
    parameter int TIMEOUT   = 2047
) (
    input  logic                  i_DTW_clk,
    input  logic                  i_DTW_rst_n,
    dtw_word_scheduler_if.master  bus
);

    localparam int W  = CHAR_NUM * 8;
    localparam int NW = $clog2(CHAR_NUM + 1);
    localparam int FW = $clog2(CAND_NUM + 1);

    typedef enum logic [2:0] {
        S_COLLECT = 3'd0,
        S_FETCH   = 3'd1,
        S_START   = 3'd2,
        S_WAIT    = 3'd3,
        S_OUT     = 3'd4
    } state_t;

    state_t            state_q;
    logic [W-1:0]      word_q;
    logic [NW-1:0]     n_q;
    logic [4:0]        g_q;
    logic              ovf_q;
    logic [W-1:0]      cand_q [0:CAND_NUM-1];
    logic [FW-1:0]     fcnt_q;
    logic [11:0]       tcnt_q;
    logic              rd_q;
    logic [ADDR_W-1:0] addr_q;
    logic              start_q;
    logic              char_rdy_q;
    logic              res_vld_q;
    logic [W-1:0]      res_word_q;
    logic              matched_q;
    logic              timeout_q;

    logic              is_eow;
    logic              first_is_letter;
    logic [4:0]        grp_d;
    logic [11:0]       tcnt_d;

    // A space terminates the word just like an explicit eow beat.
    assign is_eow          = bus.i_char_eow || (bus.i_char == 8'h20);
    assign first_is_letter = (word_q[7:0] >= 8'h61) && (word_q[7:0] <= 8'h7A);
    // 'a'..'z' are 0x61..0x7A, whose low five bits run 1..26.
    assign grp_d           = word_q[4:0] - 5'd1;
    // tcnt_d counts cycles since the start pulse; timeout fires when it reaches TIMEOUT.
    assign tcnt_d          = tcnt_q + 12'd1;

    function automatic logic [ADDR_W-1:0] grp_base(input logic [4:0] g);
        return ADDR_W'(DICT_BASE) + ADDR_W'(g) * ADDR_W'(CAND_NUM);
    endfunction

    always_ff @(posedge i_DTW_clk or posedge i_DTW_rst_n) begin
        if (i_DTW_rst_n) begin
            state_q    <= S_COLLECT;
            word_q     <= '0;
            n_q        <= '0;
            g_q        <= '0;
            ovf_q      <= 1'b0;
            for (int k = 0; k < CAND_NUM; k++) cand_q[k] <= '0;
            fcnt_q     <= '0;
            tcnt_q     <= '0;
            rd_q       <= 1'b0;
            addr_q     <= '0;
            start_q    <= 1'b0;
            char_rdy_q <= 1'b1;
            res_vld_q  <= 1'b0;
            res_word_q <= '0;
            matched_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                S_COLLECT: begin
                    if (bus.i_char_valid) begin
                        if (is_eow) begin
                            // An empty word is dropped silently.
                            if (n_q != '0) begin
                                char_rdy_q <= 1'b0;
                                if (first_is_letter) begin
                                    state_q <= S_FETCH;
                                    g_q     <= grp_d;
                                    rd_q    <= 1'b1;
                                    addr_q  <= grp_base(grp_d);
                                    fcnt_q  <= '0;
                                end else begin
                                    state_q    <= S_OUT;
                                    res_vld_q  <= 1'b1;
                                    res_word_q <= word_q;
                                    matched_q  <= 1'b0;
                                    timeout_q  <= 1'b0;
                                end
                            end
                        end else if (n_q == NW'(CHAR_NUM)) begin
                            ovf_q <= 1'b1;
                        end else begin
                            word_q[int'(n_q)*8 +: 8] <= bus.i_char;
                            n_q                      <= n_q + NW'(1);
                        end
                    end
                end

                S_FETCH: begin
                    // fcnt_q = k issues read k and captures data for read k-1;
                    // the extra final cycle only captures the last candidate.
                    if (fcnt_q != '0) cand_q[fcnt_q - FW'(1)] <= bus.i_dict_data;
                    if (fcnt_q == FW'(CAND_NUM)) begin
                        state_q <= S_START;
                        start_q <= 1'b1;
                    end else begin
                        fcnt_q <= fcnt_q + FW'(1);
                        if (fcnt_q == FW'(CAND_NUM - 1)) begin
                            rd_q <= 1'b0;
                        end else begin
                            addr_q <= grp_base(g_q) + ADDR_W'(fcnt_q) + ADDR_W'(1);
                        end
                    end
                end

                S_START: begin
                    tcnt_q  <= '0;
                    state_q <= S_WAIT;
                end

                S_WAIT: begin
                    tcnt_q <= tcnt_d;
                    // Finish has priority over a coincident timeout.
                    if (bus.i_dtw_finish) begin
                        state_q    <= S_OUT;
                        res_vld_q  <= 1'b1;
                        res_word_q <= bus.i_dtw_word;
                        matched_q  <= 1'b1;
                    end else if (tcnt_d == 12'(TIMEOUT)) begin
                        state_q    <= S_OUT;
                        res_vld_q  <= 1'b1;
                        res_word_q <= word_q;
                        timeout_q  <= 1'b1;
                    end
                end

                S_OUT: begin
                    if (bus.i_result_ready) begin
                        state_q    <= S_COLLECT;
                        char_rdy_q <= 1'b1;
                        res_vld_q  <= 1'b0;
                        word_q     <= '0;
                        n_q        <= '0;
                        ovf_q      <= 1'b0;
                        matched_q  <= 1'b0;
                        timeout_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q    <= S_COLLECT;
                    char_rdy_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.o_char_ready      = char_rdy_q;
    assign bus.o_dict_rd         = rd_q;
    assign bus.o_dict_addr       = addr_q;
    assign bus.o_dtw_start       = start_q;
    // Word and candidates are frozen while the engine runs: no chars are
    // accepted and no fetch happens outside S_COLLECT / S_FETCH.
    assign bus.o_dtw_word        = word_q;
    assign bus.o_result_valid    = res_vld_q;
    assign bus.o_result_word     = res_word_q;
    assign bus.o_result_matched  = matched_q;
    assign bus.o_result_timeout  = timeout_q;
    assign bus.o_result_overflow = ovf_q;
    assign bus.o_state           = state_q;

    for (genvar k = 0; k < CAND_NUM; k++) begin : g_cand
        assign bus.o_dtw_candidate[k] = cand_q[k];
    end

endmodule

// File: doc/dtw_word_scheduler.md
# dtw_word_scheduler

Sequencer in front of the DTW word-matching engine. Assembles a word from the glove's per-letter character stream, fetches the 20-candidate dictionary group selected by the word's first letter, and pulses the engine's start. It then waits for the engine's finish (with timeout) and returns the corrected word through a valid/ready result port. It owns the engine's word and candidate inputs and holds them stable for the whole match.

## Interface
Parameters:
- CAND_NUM, 20, candidates per dictionary group; must equal the engine's candidate count.
- CHAR_NUM, 15, maximum characters per word; word bus is CHAR_NUM*8 = 120 bits.
- ADDR_W, 10, dictionary address width.
- DICT_BASE, 0, dictionary address of group 0, candidate 0.
- TIMEOUT, 2047, maximum cycles in S_WAIT before abort; 12-bit counter.

Ports:
- i_DTW_clk  in  1  clock; all logic on the rising edge.
- i_DTW_rst_n  in  1  reset, asynchronous, active-high.
- i_char_valid  in  1  character beat valid.
- o_char_ready  out  1  character accepted when valid && ready.
- i_char  in  8  ASCII character.
- i_char_eow  in  1  end-of-word beat; i_char is ignored on this beat.
- o_dict_rd  out  1  dictionary read strobe.
- o_dict_addr  out  ADDR_W  dictionary read address.
- i_dict_data  in  120  read data, valid exactly 1 cycle after o_dict_rd.
- o_dtw_start  out  1  one-cycle start pulse to the engine.
- o_dtw_word  out  120  assembled word to the engine.
- o_dtw_candidate[0:CAND_NUM-1]  out  120 each  candidate words to the engine.
- i_dtw_finish  in  1  engine finish pulse.
- i_dtw_word  in  120  engine best-match word; valid on the finish cycle.
- o_result_valid  out  1  result available.
- i_result_ready  in  1  result consumed when valid && ready.
- o_result_word  out  120  matched word, or the raw word on bypass or timeout.
- o_result_matched  out  1  1 when o_result_word came from the engine.
- o_result_timeout  out  1  engine did not finish within TIMEOUT cycles.
- o_result_overflow  out  1  characters were dropped because the word exceeded CHAR_NUM.
- o_state  out  3  current state, for debug.

## Operation
- States: S_COLLECT=0, S_FETCH=1, S_START=2, S_WAIT=3, S_OUT=4.
- S_COLLECT
  - o_char_ready=1 in this state only.
  - Accepted character k (count n, 0..15) is written to word[8n+7:8n]; n increments. Unused bytes stay 8'h00.
  - When n==CHAR_NUM: a further character is still accepted but discarded, and the sticky overflow flag is set.
  - End of word is an accepted beat with i_char_eow=1, or i_char==8'h20 (space); the space itself is not stored.
  - End of word with n==0 is ignored; the state stays S_COLLECT.
  - First character 'a'..'z' (8'h61..8'h7A): group g = first char - 8'h61, and the next state is S_FETCH.
  - Any other first character: bypass. Next state is S_OUT with result = raw word, matched=0.
- S_FETCH
  - Issue reads k=0..CAND_NUM-1 on consecutive cycles at addr = DICT_BASE + g*CAND_NUM + k.
  - Capture i_dict_data into candidate[k] one cycle after each read.
  - The state lasts CAND_NUM+1 cycles, then moves to S_START.
- S_START: o_dtw_start=1 for exactly one cycle; clear the timeout counter; go to S_WAIT.
- S_WAIT
  - Counter increments each cycle.
  - If i_dtw_finish: capture i_dtw_word, set matched=1, go to S_OUT.
  - Else if counter==TIMEOUT: result = raw word, timeout=1, go to S_OUT.
  - If finish and timeout occur on the same cycle, finish wins.
- S_OUT
  - o_result_valid=1; result fields are held stable until accepted.
  - On i_result_ready: clear the word buffer, n, overflow, matched and timeout; return to S_COLLECT.
- o_dtw_word and o_dtw_candidate stay constant from the S_START cycle through S_WAIT; the engine reads them combinationally.
- A stray i_dtw_finish outside S_WAIT is ignored.

## Timing
- Reset values: state S_COLLECT; word buffer, candidates, n, g, counter all 0.
  - Outputs: o_char_ready=1, o_dict_rd=0, o_dict_addr=0, o_dtw_start=0, o_result_valid=0, o_result_word=0, all flags 0, o_state=0.
- Reset mid-operation abandons everything, including an in-flight engine run (the engine shares this reset). No result is produced.
- Latency, end-of-word beat to start pulse: 1 cycle to S_FETCH, 21 cycles of fetch, start asserted on cycle 22.
- Latency, finish to o_result_valid: 1 cycle.
- Bypass latency, end-of-word beat to o_result_valid: 1 cycle.
- o_result_valid may be held indefinitely; no characters are accepted meanwhile (back-pressure via o_char_ready=0).
- o_dict_rd is high for exactly CAND_NUM cycles per word.

## Test plan
- Stream "hallo" then eow, engine model returns "hello" 200 cycles after start -> reads at addresses 140..159; start on cycle 22; result "hello", matched=1, timeout=0.
- Stream "7up" then space -> no dictionary reads, no start; result 8'h70_75_37 in the low bytes, matched=0, 1 cycle after the space.
- Stream 17 letters starting 'q' -> only 15 stored; overflow=1; reads at addresses 320..339.
- Engine model never finishes -> result = raw word, timeout=1, valid asserted 2048 cycles after start.
- Finish on the exact TIMEOUT cycle -> matched=1, timeout=0; eow with 0 characters -> no state change.
- Hold i_result_ready=0 for 50 cycles, then assert reset during S_WAIT -> result held stable while pending; after reset all outputs at reset values, and the next word processes normally.
